// File: rtl/mux_8b1.sv
// ---------------------------------------------------------------------------
// mux_8b1
//
// 8-input, 1-bit-wide multiplexer driven by a one-hot 8-bit select. This is
// the bit-slice building block for the wider datapath muxes in the processor.
// The data output is produced combinationally. A registered copy of that
// output and a registered select-validity flag are also provided.
//
// Ports
//   CLK      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous active-low reset
//   A..H     in   1  data inputs 0..7, selected by S[0]..S[7]
//   S        in   8  one-hot select
//   O        out  1  combinational mux output (OR of all selected inputs)
//   O_q      out  1  O registered on CLK
//   sel_err  out  1  registered flag: S was not exactly one-hot at last edge
//   err_cnt  out  8  saturating count of edges with an invalid select
//                    (present only when MUX8B1_ERRCNT_EN is defined)
//
// Configuration
//   MUX8B1_ERRCNT_EN  when defined, adds the err_cnt port and its counter.
//                     Nothing else in the design changes.
// ---------------------------------------------------------------------------
module mux_8b1 (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       H,
    input  logic [7:0] S,
    output logic       O,
    output logic       O_q,
    output logic       sel_err
`ifdef MUX8B1_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    logic [7:0] dataIn;
    logic [7:0] selTerm;
    logic       selOneHot;

    logic       outReg_q;
    logic       outReg_d;
    logic       selErr_q;
    logic       selErr_d;

    assign dataIn = {H, G, F, E, D, C, B, A};

    // The mux is built as a flat AND-OR. Each input is gated by its own
    // select bit, so an X/Z on an unselected input is ANDed with 0 and cannot
    // reach O. With multi-hot selects, the selected inputs are simply ORed
    // together, and no select bit has priority over another.
    assign selTerm = dataIn & S;
    assign O       = |selTerm;

    // S is exactly one-hot when it is non-zero and has no second bit set.
    // Clearing the lowest set bit (S & (S-1)) leaves zero only in that case.
    assign selOneHot = (S != 8'd0) && ((S & (S - 8'd1)) == 8'd0);

    // Next-state values for the two status registers.
    always_comb begin
        outReg_d = O;
        selErr_d = ~selOneHot;
    end

    // Registered output and select-error flag. Reset clears both
    // immediately, so no value pending from before the reset survives it.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            outReg_q <= 1'b0;
            selErr_q <= 1'b0;
        end else begin
            outReg_q <= outReg_d;
            selErr_q <= selErr_d;
        end
    end

    assign O_q     = outReg_q;
    assign sel_err = selErr_q;

`ifdef MUX8B1_ERRCNT_EN
    logic [7:0] errCnt_q;
    logic [7:0] errCnt_d;

    // The counter advances once for every edge that sees an invalid select.
    // It sticks at 255 so a long-running fault never wraps back to a small
    // value.
    always_comb begin
        errCnt_d = errCnt_q;
        if (!selOneHot && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    // Error counter register, cleared asynchronously with the rest of the
    // state.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            errCnt_q <= 8'd0;
        end else begin
            errCnt_q <= errCnt_d;
        end
    end

    assign err_cnt = errCnt_q;
`endif

endmodule

// File: tb/tb_mux_8b1.sv
// ---------------------------------------------------------------------------
// tb_mux_8b1
//
// Self-checking bench for mux_8b1. A behavioural reference model predicts the
// combinational output and the registered state from the mux rules. A compare
// process checks the DUT against that model on every falling clock edge.
// Directed scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_mux_8b1;

    logic       CLK;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] sel;
    logic       O;
    logic       O_q;
    logic       sel_err;
`ifdef MUX8B1_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks;
    int errors;

    logic       modelOq;
    logic       modelErr;
    int         modelCnt;

    mux_8b1 dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .A       (din[0]),
        .B       (din[1]),
        .C       (din[2]),
        .D       (din[3]),
        .E       (din[4]),
        .F       (din[5]),
        .G       (din[6]),
        .H       (din[7]),
        .S       (sel),
        .O       (O),
        .O_q     (O_q),
        .sel_err (sel_err)
`ifdef MUX8B1_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    // Free-running clock with a 10 ns period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference output: the result is 1 when any selected input is 1.
    function automatic logic modelMux(input logic [7:0] d, input logic [7:0] s);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s[k] === 1'b1 && d[k] === 1'b1) r = 1'b1;
        end
        return r;
    endfunction

    // Reference validity: a select is valid only when exactly one bit is set.
    function automatic logic modelSelBad(input logic [7:0] s);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (s[k] === 1'b1) n++;
        end
        return (n != 1);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time,
                     actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] s);
        @(posedge CLK);
        #1;
        din = d;
        sel = s;
    endtask

    // Behavioural model of the registered state.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            modelOq  <= 1'b0;
            modelErr <= 1'b0;
            modelCnt <= 0;
        end else begin
            modelOq  <= modelMux(din, sel);
            modelErr <= modelSelBad(sel);
            if (modelSelBad(sel) && modelCnt < 255) modelCnt <= modelCnt + 1;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge CLK) begin
        checkOutput("O_cycle", {7'd0, O}, {7'd0, modelMux(din, sel)});
        checkOutput("O_q_cycle", {7'd0, O_q}, {7'd0, modelOq});
        checkOutput("sel_err_cycle", {7'd0, sel_err}, {7'd0, modelErr});
`ifdef MUX8B1_ERRCNT_EN
        checkOutput("err_cnt_cycle", err_cnt, modelCnt[7:0]);
`endif
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] oneHot;
        int         pick;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        din    = 8'h00;
        sel    = 8'h00;

        // Reset state, checked between clock edges.
        #12;
        checkOutput("reset_O_q", {7'd0, O_q}, 8'h00);
        checkOutput("reset_sel_err", {7'd0, sel_err}, 8'h00);
        rst_n = 1'b1;

        // Only H is high and S selects H.
        applyStimulus(8'h80, 8'h80);
        #1;
        checkOutput("h_sel_O", {7'd0, O}, 8'h01);
        @(posedge CLK);
        #2;
        checkOutput("h_sel_O_q", {7'd0, O_q}, 8'h01);
        checkOutput("h_sel_err", {7'd0, sel_err}, 8'h00);

        // Walk each select bit, first with only the selected input high,
        // then with only the selected input low.
        for (int k = 0; k < 8; k++) begin
            oneHot = 8'd1 << k;
            applyStimulus(oneHot, oneHot);
            #1;
            checkOutput("walk_high_O", {7'd0, O}, 8'h01);
            applyStimulus(~oneHot, oneHot);
            #1;
            checkOutput("walk_low_O", {7'd0, O}, 8'h00);
        end

        // An empty select gives a 0 output and raises the error flag.
        applyStimulus(8'hFF, 8'h00);
        #1;
        checkOutput("zero_sel_O", {7'd0, O}, 8'h00);
        @(posedge CLK);
        #2;
        checkOutput("zero_sel_err", {7'd0, sel_err}, 8'h01);
        checkOutput("zero_sel_O_q", {7'd0, O_q}, 8'h00);

        // A multi-hot select ORs the selected inputs and flags an error.
        // The flag clears again once the select is valid.
        applyStimulus(8'h80, 8'h81);
        #1;
        checkOutput("multi_hot_O", {7'd0, O}, 8'h01);
        @(posedge CLK);
        #2;
        checkOutput("multi_hot_err", {7'd0, sel_err}, 8'h01);
        applyStimulus(8'h80, 8'h01);
        #1;
        checkOutput("a_only_O", {7'd0, O}, 8'h00);
        @(posedge CLK);
        #2;
        checkOutput("a_only_err", {7'd0, sel_err}, 8'h00);

        // An X on an unselected input must not reach O.
        @(posedge CLK);
        #1;
        din    = 8'hxx;
        din[7] = 1'b1;
        sel    = 8'h80;
        #1;
        checkOutput("x_unselected_O", {7'd0, O}, 8'h01);
        applyStimulus(8'h00, 8'h00);

        // Assert reset between edges while O_q and sel_err are both 1.
        applyStimulus(8'h80, 8'h81);
        @(posedge CLK);
        #2;
        checkOutput("pre_reset_O_q", {7'd0, O_q}, 8'h01);
        checkOutput("pre_reset_err", {7'd0, sel_err}, 8'h01);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_O_q", {7'd0, O_q}, 8'h00);
        checkOutput("async_reset_err", {7'd0, sel_err}, 8'h00);
        din = 8'h80;
        sel = 8'h80;
        #3;
        rst_n = 1'b1;
        @(posedge CLK);
        #2;
        checkOutput("post_reset_O_q", {7'd0, O_q}, 8'h01);
        checkOutput("post_reset_err", {7'd0, sel_err}, 8'h00);

        // Randomized traffic with a mix of one-hot, arbitrary and empty selects.
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 3);
            if (pick <= 1)      oneHot = 8'd1 << $urandom_range(0, 7);
            else if (pick == 2) oneHot = 8'($urandom);
            else                oneHot = 8'h00;
            applyStimulus(8'($urandom), oneHot);
        end

`ifdef MUX8B1_ERRCNT_EN
        // Hold an invalid select long enough to saturate the counter,
        // then clear it with reset.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(8'($urandom), 8'h00);
        end
        @(posedge CLK);
        #2;
        checkOutput("err_cnt_saturated", err_cnt, 8'hFF);
        rst_n = 1'b0;
        #1;
        checkOutput("err_cnt_reset", err_cnt, 8'h00);
        #4;
        rst_n = 1'b1;
`endif

        repeat (2) @(posedge CLK);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
